// File: rtl/serial_frame_tx_1011.sv
// Serial framing transmitter: emits preamble 1011 then the payload MSB-first,
// followed by GAP forced-idle bits. Words are accepted only while idle.
module serial_frame_tx_1011 #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             out,
   output logic             busy,
   output logic             sync_mark,
   output logic             done
);

   localparam int WG   = (WIDTH > GAP) ? WIDTH : GAP;
   localparam int MAXC = (WG > 4) ? WG : 4;
   localparam int CW   = $clog2(MAXC);

   localparam logic [CW-1:0] PRE_LAST = CW'(3);
   localparam logic [CW-1:0] W_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] G_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [3:0]    PREAMBLE = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             sync_q, sync_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         sync_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         sync_q  <= sync_d;
         done_q  <= done_d;
      end
   end

   assign cnt_inc = cnt_q + CW'(1);

   // Next-state logic computes the bit that will be on the line next cycle,
   // so out and its markers are registered with zero acceptance latency.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      out_d   = 1'b0;
      sync_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               state_d = S_PRE;
               cnt_d   = '0;
               sr_d    = data_in;
               out_d   = PREAMBLE[3];
            end
         end
         S_PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = S_DATA;
               cnt_d   = '0;
               out_d   = sr_q[WIDTH-1];
               sr_d    = sr_q << 1;
               done_d  = (W_LAST == '0);
            end else begin
               cnt_d  = cnt_inc;
               // Preamble position p maps to PREAMBLE[3-p], i.e. the inverted index.
               out_d  = PREAMBLE[~cnt_inc[1:0]];
               sync_d = (cnt_inc == PRE_LAST);
            end
         end
         S_DATA: begin
            if (cnt_q == W_LAST) begin
               cnt_d   = '0;
               state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end else begin
               cnt_d  = cnt_inc;
               out_d  = sr_q[WIDTH-1];
               sr_d   = sr_q << 1;
               done_d = (cnt_inc == W_LAST);
            end
         end
         S_GAP: begin
            if (cnt_q == G_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign ready_out = (state_q == S_IDLE);
   assign out       = out_q;
   assign busy      = busy_q;
   assign sync_mark = sync_q;
   assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx_1011.sv
// Bench for serial_frame_tx_1011: a default (8,2) instance and a (4,0) instance,
// checked cycle by cycle against a frame-level model, plus a loopback 1011 detector.
module tb_serial_frame_tx_1011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data8;
   logic       valid8;
   logic       rdy8, o8, busy8, sync8, done8;
   logic [3:0] data4;
   logic       valid4;
   logic       rdy4, o4, busy4, sync4, done4;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [3:0] det_hist = 4'b0;
   logic       det_flag = 1'b0;

   always #5 clk = ~clk;

   serial_frame_tx_1011 #(.WIDTH(8), .GAP(2)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data8), .valid_in(valid8),
      .ready_out(rdy8), .out(o8), .busy(busy8), .sync_mark(sync8), .done(done8)
   );

   serial_frame_tx_1011 #(.WIDTH(4), .GAP(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(data4), .valid_in(valid4),
      .ready_out(rdy4), .out(o4), .busy(busy4), .sync_mark(sync4), .done(done4)
   );

   // Loopback sequence detector sampling the line on clk.
   always @(posedge clk) begin
      det_hist <= {det_hist[2:0], o8};
      det_flag <= ({det_hist[2:0], o8} == 4'b1011);
   end

   // Reference model: expected {out, sync_mark, done, busy, ready_out} in cycle Ck
   // of a frame carrying d, with k past the frame meaning idle.
   function automatic logic [4:0] exp_vec(int k, logic [31:0] d, int w, int gap);
      logic [3:0] pre;
      logic       ob;
      logic       bz;
      pre = 4'b1011;
      ob  = 1'b0;
      if (k >= 1 && k <= 4) ob = pre[4-k];
      else if (k >= 5 && k <= 4 + w) ob = d[w + 4 - k];
      bz = (k >= 1) && (k <= 4 + w + gap);
      return {ob, (k == 4), (k == 4 + w), bz, ~bz};
   endfunction

   // Expected detector flag in cycle Ck: last four line bits before Ck were 1011.
   function automatic logic exp_flag(int k, logic [31:0] d);
      logic [3:0] win;
      for (int j = 0; j < 4; j++) win[3-j] = exp_vec(k - 4 + j, d, 8, 2)[4];
      return (win == 4'b1011);
   endfunction

   function automatic logic [4:0] obs8();
      return {o8, sync8, done8, busy8, rdy8};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; valid8 = 1'b1; data8 = 8'hFF; valid4 = 1'b0; data4 = 4'h0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (obs8() !== 5'b00001)
         $display("FAIL reset_dut8 got=%b want=%b", obs8(), 5'b00001);
      else pass_cnt++;
      total_cnt++;
      if ({o4, sync4, done4, busy4, rdy4} !== 5'b00001)
         $display("FAIL reset_dut4 got=%b want=%b", {o4, sync4, done4, busy4, rdy4}, 5'b00001);
      else pass_cnt++;
      valid8 = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single(input logic [7:0] d, input string nm);
      data8 = d; valid8 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) begin valid8 = 1'b0; data8 = 8'($urandom); end
         total_cnt++;
         if (obs8() !== exp_vec(k, {24'b0, d}, 8, 2))
            $display("FAIL %s C%0d data=%h got=%b want=%b", nm, k, d, obs8(), exp_vec(k, {24'b0, d}, 8, 2));
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         test_single(8'($urandom), "random_frame");
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      data8 = 8'h3C; valid8 = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         if (k == 1) data8 = 8'hC3;
         if (k == 16) valid8 = 1'b0;
         e = (k <= 15) ? exp_vec(k, 32'h3C, 8, 2) : exp_vec(k - 15, 32'hC3, 8, 2);
         total_cnt++;
         if (obs8() !== e) $display("FAIL back_to_back C%0d got=%b want=%b", k, obs8(), e);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignore_busy();
      logic [7:0] d;
      d = 8'($urandom);
      data8 = d; valid8 = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         total_cnt++;
         if (obs8() !== exp_vec(k, {24'b0, d}, 8, 2))
            $display("FAIL ignore_busy C%0d data=%h got=%b want=%b", k, d, obs8(), exp_vec(k, {24'b0, d}, 8, 2));
         else pass_cnt++;
         if (k == 3 || k == 9) begin valid8 = 1'b1; data8 = 8'hFF; end
         else begin valid8 = 1'b0; data8 = 8'($urandom); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'($urandom);
      data8 = d; valid8 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) valid8 = 1'b0;
         total_cnt++;
         if (obs8() !== exp_vec(k, {24'b0, d}, 8, 2))
            $display("FAIL midreset_pre C%0d got=%b want=%b", k, obs8(), exp_vec(k, {24'b0, d}, 8, 2));
         else pass_cnt++;
      end
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (obs8() !== 5'b00001) $display("FAIL midreset_async got=%b want=%b", obs8(), 5'b00001);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         total_cnt++;
         if (obs8() !== 5'b00001) $display("FAIL midreset_residual cyc%0d got=%b want=%b", k, obs8(), 5'b00001);
         else pass_cnt++;
      end
      test_single(8'($urandom), "after_reset_frame");
   endtask

   task automatic test_gap0();
      logic [4:0] e;
      logic [4:0] got;
      data4 = 4'h6; valid4 = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 10) valid4 = 1'b0;
         e = (k <= 9) ? exp_vec(k, 32'h6, 4, 0) : exp_vec(k - 9, 32'h6, 4, 0);
         got = {o4, sync4, done4, busy4, rdy4};
         total_cnt++;
         if (got !== e) $display("FAIL gap0 C%0d got=%b want=%b", k, got, e);
         else pass_cnt++;
      end
   endtask

   task automatic test_loopback(input logic [7:0] d, input int want_hits);
      int hits;
      hits = 0;
      repeat (6) @(negedge clk);
      data8 = d; valid8 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) valid8 = 1'b0;
         if (det_flag === 1'b1) hits++;
         total_cnt++;
         if (det_flag !== exp_flag(k, {24'b0, d}))
            $display("FAIL loopback_flag data=%h C%0d got=%b want=%b", d, k, det_flag, exp_flag(k, {24'b0, d}));
         else pass_cnt++;
      end
      total_cnt++;
      if (hits != want_hits) $display("FAIL loopback_hits data=%h got=%0d want=%0d", d, hits, want_hits);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single(8'hA5, "single_A5");
      test_random();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midframe();
      test_gap0();
      test_loopback(8'hA5, 1);
      test_loopback(8'hB0, 2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
